// File: rtl/alu_exec_stage.sv
// ----------------------------------------------------------------------------
// alu_exec_stage
//   Execute stage of a small register-file datapath. Single-cycle ALU ops
//   (ADD/SUB/AND/OR/XOR/SLL/SRL) write back one cycle after acceptance.
//   MUL is an optional iterative shift-add multiplier (DW steps, one per clock)
//   that returns the low DW bits of the product.
//
//   Build option: define ALU_MUL_EN to include the MULT state and multiplier
//   datapath. Without it, opcode 111 is accepted and discarded (no write-back,
//   flags untouched) and busy is tied low.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand bundle handshake (accept when both high)
//   op, busA, busB,rd opcode, source operands, destination index
//   wb_rw, wb_busW    write-back index/data, held between completions
//   wb_wren           one-cycle write-back strobe
//   flag_z, flag_c    zero/carry of the last written-back result
//   busy              multiply in progress
//
// state | meaning
// IDLE  | ready; single-cycle ops complete here, MUL starts here
// MULT  | shift-add multiply, one step per cycle, DW steps
// ----------------------------------------------------------------------------
module alu_exec_stage #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [DW-1:0] busA,
    input  logic [DW-1:0] busB,
    input  logic [AW-1:0] rd,
    output logic [AW-1:0] wb_rw,
    output logic [DW-1:0] wb_busW,
    output logic          wb_wren,
    output logic          flag_z,
    output logic          flag_c,
    output logic          busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic          accept;
    logic [DW-1:0] alu_res;
    logic          alu_carry;

    logic          wb_wren_q, wb_wren_d;
    logic [DW-1:0] wb_busW_q, wb_busW_d;
    logic [AW-1:0] wb_rw_q,   wb_rw_d;
    logic          flag_z_q,  flag_z_d;
    logic          flag_c_q,  flag_c_d;

    assign accept = in_valid && in_ready;

    // Single-cycle ALU. MUL (and the disabled-MUL case) yields nothing here.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD:  {alu_carry, alu_res} = {1'b0, busA} + {1'b0, busB};
            OP_SUB: begin
                alu_res   = busA - busB;
                alu_carry = (busA < busB);
            end
            OP_AND:  alu_res = busA & busB;
            OP_OR:   alu_res = busA | busB;
            OP_XOR:  alu_res = busA ^ busB;
            OP_SLL:  alu_res = busA << busB[3:0];
            OP_SRL:  alu_res = busA >> busB[3:0];
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic {IDLE = 1'b0, MULT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] mul_a_q, mul_b_q, acc_q;
    logic [AW-1:0] mul_rd_q;
    logic [DW-1:0] mul_sum;
    logic          mul_done;

    // Partial sum including the current step; on the last step this is the product.
    assign mul_sum  = acc_q + (mul_b_q[0] ? mul_a_q : '0);
    assign mul_done = (state_q == MULT) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && op == OP_MUL) state_d = MULT;
            MULT:    if (cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == MULT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            mul_rd_q <= '0;
        end else if (accept && op == OP_MUL) begin
            cnt_q    <= '0;
            mul_a_q  <= busA;
            mul_b_q  <= busB;
            acc_q    <= '0;
            mul_rd_q <= rd;
        end else if (state_q == MULT) begin
            cnt_q   <= mul_done ? '0 : cnt_q + 1'b1;
            acc_q   <= mul_sum;
            mul_a_q <= mul_a_q << 1;
            mul_b_q <= mul_b_q >> 1;
        end
    end
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    // Write-back: pulse on completion, otherwise hold index/data/flags.
    always_comb begin
        wb_wren_d = 1'b0;
        wb_busW_d = wb_busW_q;
        wb_rw_d   = wb_rw_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        if (accept && op != OP_MUL) begin
            wb_wren_d = 1'b1;
            wb_busW_d = alu_res;
            wb_rw_d   = rd;
            flag_z_d  = (alu_res == '0);
            flag_c_d  = alu_carry;
        end
`ifdef ALU_MUL_EN
        else if (mul_done) begin
            wb_wren_d = 1'b1;
            wb_busW_d = mul_sum;
            wb_rw_d   = mul_rd_q;
            flag_z_d  = (mul_sum == '0);
            flag_c_d  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_wren_q <= 1'b0;
            wb_busW_q <= '0;
            wb_rw_q   <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            wb_wren_q <= wb_wren_d;
            wb_busW_q <= wb_busW_d;
            wb_rw_q   <= wb_rw_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
        end
    end

    assign wb_wren = wb_wren_q;
    assign wb_busW = wb_busW_q;
    assign wb_rw   = wb_rw_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

endmodule
